// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM states, stall vector constants, stage bit indices.
package pipe_ctrl_pkg;

  localparam int unsigned NUM_STAGES = 5;

  typedef enum logic [1:0] {
    PC_RUN   = 2'd0,
    PC_WAIT  = 2'd1,
    PC_FLUSH = 2'd2
  } pc_state_e;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;

  // Each constant holds the requesting stage and everything upstream of it.
  localparam logic [NUM_STAGES-1:0] STALL_NONE = 5'b00000;
  localparam logic [NUM_STAGES-1:0] STALL_IF   = 5'b00001;
  localparam logic [NUM_STAGES-1:0] STALL_ID   = 5'b00011;
  localparam logic [NUM_STAGES-1:0] STALL_EX   = 5'b00111;
  localparam logic [NUM_STAGES-1:0] STALL_MEM  = 5'b01111;
  localparam logic [NUM_STAGES-1:0] STALL_ALL  = 5'b11111;

endpackage

// File: rtl/pipe_ctrl_stall_counter.sv
// Wrapping up-counter with synchronous clear (priority over enable).
module stall_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush control for the 5-stage core, with exception drain
// sequencing and a stall-cycle performance counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_if,
  input  logic              req_id,
  input  logic              req_ex,
  input  logic              req_mem,
  input  logic              excp_req,
  input  logic [ADDR_W-1:0] excp_target,
  input  logic              ibus_busy,
  input  logic              dbus_busy,
  input  logic              cnt_clr,
  output logic [4:0]        stall,
  output logic              flush,
  output logic [ADDR_W-1:0] flush_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  pc_state_e             state_q;
  pc_state_e             state_d;
  logic [ADDR_W-1:0]     target_q;
  logic                  target_ld;
  logic [NUM_STAGES-1:0] stall_vec;
  logic                  bus_idle;

  assign bus_idle = !ibus_busy && !dbus_busy;

  // State and latched redirect target.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= PC_RUN;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      if (target_ld) begin
        target_q <= excp_target;
      end
    end
  end

  // Next state and stall vector; the first exception wins until the flush issues.
  always_comb begin
    state_d   = state_q;
    stall_vec = STALL_NONE;
    target_ld = 1'b0;
    unique case (state_q)
      PC_RUN: begin
        if (excp_req) begin
          stall_vec = STALL_ALL;
          target_ld = 1'b1;
          state_d   = bus_idle ? PC_FLUSH : PC_WAIT;
        end else if (req_mem) begin
          stall_vec = STALL_MEM;
        end else if (req_ex) begin
          stall_vec = STALL_EX;
        end else if (req_id) begin
          stall_vec = STALL_ID;
        end else if (req_if) begin
          stall_vec = STALL_IF;
        end
      end
      PC_WAIT: begin
        stall_vec = STALL_ALL;
        if (bus_idle) begin
          state_d = PC_FLUSH;
        end
      end
      PC_FLUSH: begin
        state_d = PC_RUN;
      end
      default: begin
        state_d = PC_RUN;
      end
    endcase
  end

  // Reset forces a clean all-zero stall vector even if requests are active.
  assign stall    = resetn ? stall_vec : STALL_NONE;
  assign flush    = (state_q == PC_FLUSH);
  assign flush_pc = flush ? target_q : '0;

  stall_counter #(
    .CNT_W(CNT_W)
  ) u_stall_counter (
    .clk    (clk),
    .resetn (resetn),
    .clr    (cnt_clr),
    .en     (stall[STG_IF]),
    .cnt    (stall_cnt)
  );

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline control for the 5-stage core.
- Produces the per-stage stall vector and the flush pulse consumed by the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.
- Sequences exception/ERET entry: freezes the pipe, waits for uncancellable bus transactions to drain, then issues a one-cycle flush with the redirect PC.
- Keeps a stall-cycle performance counter.

Parameters:
- CNT_W, 32, width of stall-cycle counter.
- ADDR_W, 32, width of redirect PC.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- req_if  in  1  stall request from IF (icache miss)
- req_id  in  1  stall request from ID (load-use hazard)
- req_ex  in  1  stall request from EX (mul/div busy)
- req_mem  in  1  stall request from MEM (dcache miss)
- excp_req  in  1  exception or ERET committed in MEM
- excp_target  in  ADDR_W  handler/EPC address, valid with excp_req
- ibus_busy  in  1  instruction bus transaction outstanding
- dbus_busy  in  1  data bus transaction outstanding
- cnt_clr  in  1  synchronous clear of stall_cnt
- stall  out  5  {wb,mem,ex,id,if} stall bits; bit i set means stage i holds
- flush  out  1  one-cycle pipeline flush
- flush_pc  out  ADDR_W  redirect PC, valid while flush=1
- stall_cnt  out  CNT_W  cycles with stall[0]=1

Behaviour:
- States: RUN, WAIT, FLUSH. State encoding is 2 bits, held in registers.
- Reset (resetn=0, async): state=RUN, latched target=0, stall_cnt=0.
  - Outputs during reset: stall=5'b00000, flush=0, flush_pc=0.
- RUN, excp_req=0:
  - Stall vector is priority-encoded by the highest requesting stage, combinationally.
    - req_mem: 5'b01111
    - else req_ex: 5'b00111
    - else req_id: 5'b00011
    - else req_if: 5'b00001
    - else: 5'b00000
  - A lower stage's request never stalls a later stage.
  - Downstream registers see {stall[i+1],stall[i]}=01 as a bubble insert. This is guaranteed by the encoding.
- RUN, excp_req=1 (overrides all req_*):
  - stall=5'b11111 in that cycle.
  - excp_target latched on the clock edge.
  - Next state: FLUSH if ibus_busy=0 and dbus_busy=0, else WAIT.
- WAIT:
  - stall=5'b11111, flush=0.
  - excp_req and req_* ignored.
  - Go to FLUSH on the first cycle where both busy inputs are 0 (sampled that cycle). Stay otherwise; there is no timeout.
- FLUSH (exactly one cycle):
  - flush=1, flush_pc=latched target, stall=5'b00000.
  - req_* and excp_req ignored.
  - Next state: RUN.
- flush_pc reads 0 whenever flush=0.
- Exception-to-flush latency:
  - 1 cycle after the excp_req cycle if not busy.
  - Otherwise 1 cycle after busy clears.
- excp_req arriving in WAIT or FLUSH: dropped. The first exception wins; upstream guarantees no second commit while frozen.
- stall_cnt:
  - Increments on each clock where stall[0]=1. WAIT and excp_req cycles count.
  - Wraps from all-ones to 0.
  - cnt_clr takes priority over increment; the counter reads 0 the next cycle.
- Reset mid-WAIT/FLUSH: immediate return to RUN. The pending target is discarded.

Decomposition:
- Shared defines (alongside existing ones):
  - state encodings PC_RUN/PC_WAIT/PC_FLUSH
  - stall vector constants STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM, STALL_ALL
  - stage bit indices
- One sub-module: stall_counter (CNT_W-bit wrapping counter with clear and enable).

Test Plan:
- Reset then idle: resetn low 3 cycles, all req 0. Expected: stall=00000, flush=0, stall_cnt=0. Then req_ex=1 for 4 cycles: stall=00111 each cycle, stall_cnt=4.
- Priority: req_if=req_id=req_mem=1 -> stall=01111. Drop req_mem -> stall=00011 the same cycle.
- Fast exception: excp_req=1, excp_target=0xBFC00380, busies 0.
  - Cycle 0: stall=11111.
  - Cycle 1: flush=1, flush_pc=0xBFC00380, stall=00000.
  - Cycle 2: RUN, flush=0, flush_pc=0.
- Drained exception: excp_req with dbus_busy=1 for 5 cycles.
  - stall=11111 for 6 cycles total.
  - flush asserts the cycle after dbus_busy falls.
  - A second excp_req (target 0x80000180) during WAIT is ignored: flush_pc=0xBFC00380.
- Counter wrap/clear: preload via long stall with CNT_W=4. 16 stalled cycles -> stall_cnt wraps to 0. cnt_clr together with stall -> 0.
- Async reset in WAIT: deassert resetn mid-WAIT. Outputs go to reset values immediately (no clock edge). After release, stall=00000 and flush never pulses.
